trade_history_buffer: RTL and testbench
=======================================

TRADE_HISTORY_BUFFER -- requirements
Module: trade_history_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of stored trade prices; power of two, 4..64.
REQ-002 SHALL have parameter PW, default 8, price width in bits.
REQ-003 SHALL have parameter AW, default 4, address width, equal to log2(DEPTH).
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port match_signal, input, 1 bit: one-cycle trade strobe from matching_engine.
REQ-007 SHALL have port trade_price, input, PW bits: executed price, valid when match_signal=1.
REQ-008 SHALL have port halt_signal, input, 1 bit: session halted; suppresses capture.
REQ-009 SHALL have port freeze, input, 1 bit: VGA frame-scan hold; captures are queued, not written.
REQ-010 SHALL have port rd_age, input, AW bits: read index by age; 0 = newest trade.
REQ-011 SHALL have port rd_data, output, PW bits: registered price at rd_age.
REQ-012 SHALL have port rd_valid, output, 1 bit: registered; 1 when rd_age < count at sample time.
REQ-013 SHALL have port count, output, AW+1 bits: number of valid entries, 0..DEPTH.
REQ-014 SHALL have port full, output, 1 bit: count==DEPTH.
REQ-015 SHALL have port last_price, output, PW bits: most recently written price.
REQ-016 SHALL have port max_price, output, PW bits: session maximum trade price.
REQ-017 SHALL have port min_price, output, PW bits: session minimum trade price.
REQ-018 SHALL have port dropped, output, 1 bit: sticky flag; a trade was lost while freeze pending slot was occupied.

Function
REQ-019 SHALL store prices in a DEPTH-entry circular array with write pointer wr_ptr (AW bits, wraps DEPTH-1 -> 0).
REQ-020 SHALL treat an accepted trade as match_signal=1 and halt_signal=0; match_signal during halt SHALL be ignored entirely.
REQ-021 With freeze=0 and no pending entry, an accepted trade SHALL be written at wr_ptr at that edge, wr_ptr incremented, and count incremented and saturated at DEPTH.
REQ-022 With freeze=1, an accepted trade SHALL be held in a one-entry pending register; a second accepted trade while pending is full SHALL overwrite pending and set dropped.
REQ-023 When freeze falls to 0, the pending entry SHALL be written on the first cycle with freeze=0; if an accepted trade arrives that same cycle, pending is written first and the new trade becomes pending (written next cycle).
REQ-024 When full, a write SHALL overwrite the oldest entry; count stays DEPTH.
REQ-025 rd_data SHALL equal mem[(wr_ptr-1-rd_age) mod DEPTH], registered, with 1-cycle latency from rd_age; a write on the same edge SHALL NOT be visible until the following read.
REQ-026 When rd_age >= count, rd_valid SHALL be 0 and rd_data SHALL be 0.
REQ-027 last_price, max_price and min_price SHALL update on the same edge as the array write, not on pending capture.
REQ-028 The first write after reset SHALL load both max_price and min_price with that price; later writes use unsigned compare, with ties leaving the value unchanged.
REQ-029 While count==0, max_price, min_price and last_price SHALL read 0.
REQ-030 freeze SHALL NOT affect the read path or the statistics outputs.

Reset
REQ-031 reset=1 at an edge SHALL clear wr_ptr, count, full, pending, dropped, last_price, max_price, min_price, rd_data and rd_valid to 0, and discard any pending trade, including mid-freeze.
REQ-032 Array contents need not be cleared; they SHALL be unobservable because rd_valid=0 while count==0.
REQ-033 reset SHALL take priority over a simultaneous match_signal.

Verification
REQ-034 Write 10,20,30 (one per pulse), rd_age=0..3 -> rd_data 30,20,10,0; rd_valid 1,1,1,0; count=3; max=30; min=10.
REQ-035 Write 17 trades of prices 1..17 -> count=16, full=1, rd_age=0 gives 17, rd_age=15 gives 2; wr_ptr wrapped to 1.
REQ-036 Hold halt_signal=1 and pulse match with 99 -> count, last_price and statistics unchanged.
REQ-037 freeze=1, trades 40 then 50, then freeze=0 -> dropped=1, only 50 written, one cycle after the freeze fall; last_price=50.
REQ-038 freeze falls on the same cycle a trade of 60 arrives, with 55 pending -> 55 written that cycle, 60 written next cycle; rd_age=0 gives 60.
REQ-039 Assert reset during freeze with an entry pending -> all outputs 0, pending discarded; first subsequent trade 8 gives max=min=last=8 and count=1.

Source files
------------

// File: rtl/trade_history_buffer.sv
// Circular history of executed trade prices with age-indexed registered read,
// freeze-time one-entry pending capture and running session statistics.
module trade_history_buffer #(
    parameter int DEPTH = 16,
    parameter int PW    = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          match_signal,
    input  logic [PW-1:0] trade_price,
    input  logic          halt_signal,
    input  logic          freeze,
    input  logic [AW-1:0] rd_age,
    output logic [PW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic [PW-1:0] last_price,
    output logic [PW-1:0] max_price,
    output logic [PW-1:0] min_price,
    output logic          dropped
);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic          pend_valid;
    logic [PW-1:0] pend_price;

    logic          accept;
    logic          do_write;
    logic [PW-1:0] wr_data;
    logic [AW-1:0] rd_idx;
    logic          age_ok;

    assign accept = match_signal & ~halt_signal;
    assign full   = (count == (AW+1)'(DEPTH));
    // DEPTH is a power of two, so AW-bit wraparound gives the modulo for free
    assign rd_idx = wr_ptr - AW'(1) - rd_age;
    assign age_ok = ({1'b0, rd_age} < count);

    // A pending entry always drains before a fresh trade can reach the array
    always_comb begin
        do_write = 1'b0;
        wr_data  = trade_price;
        if (!freeze) begin
            if (pend_valid) begin
                do_write = 1'b1;
                wr_data  = pend_price;
            end else if (accept) begin
                do_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            count      <= '0;
            pend_valid <= 1'b0;
            pend_price <= '0;
            dropped    <= 1'b0;
            last_price <= '0;
            max_price  <= '0;
            min_price  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= age_ok;
            rd_data  <= age_ok ? mem[rd_idx] : '0;

            if (do_write) begin
                wr_ptr     <= wr_ptr + AW'(1);
                last_price <= wr_data;
                if (!full) begin
                    count <= count + (AW+1)'(1);
                end
                if (count == '0) begin
                    max_price <= wr_data;
                    min_price <= wr_data;
                end else begin
                    if (wr_data > max_price) max_price <= wr_data;
                    if (wr_data < min_price) min_price <= wr_data;
                end
            end

            if (freeze) begin
                if (accept) begin
                    if (pend_valid) dropped <= 1'b1;
                    pend_price <= trade_price;
                    pend_valid <= 1'b1;
                end
            end else if (pend_valid) begin
                // Pending drains this edge; a same-cycle trade takes its place
                if (accept) begin
                    pend_price <= trade_price;
                end else begin
                    pend_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_trade_history_buffer.sv
// Randomized and directed bench for trade_history_buffer against a queue-based
// model of the trade history, pending slot and session statistics.
module tb_trade_history_buffer;

    localparam int DEPTH = 16;
    localparam int PW    = 8;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          match_signal;
    logic [PW-1:0] trade_price;
    logic          halt_signal;
    logic          freeze;
    logic [AW-1:0] rd_age;
    logic [PW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          full;
    logic [PW-1:0] last_price;
    logic [PW-1:0] max_price;
    logic [PW-1:0] min_price;
    logic          dropped;

    trade_history_buffer #(.DEPTH(DEPTH), .PW(PW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .match_signal (match_signal),
        .trade_price  (trade_price),
        .halt_signal  (halt_signal),
        .freeze       (freeze),
        .rd_age       (rd_age),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .last_price   (last_price),
        .max_price    (max_price),
        .min_price    (min_price),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: hist[0] is the newest written price
    int hist[$];
    bit m_pend_v;
    int m_pend;
    bit m_dropped;
    int m_last, m_max, m_min;
    int e_rdd;
    bit e_rdv;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int p);
        if (hist.size() == 0) begin
            m_max = p;
            m_min = p;
        end else begin
            if (p > m_max) m_max = p;
            if (p < m_min) m_min = p;
        end
        m_last = p;
        hist.push_front(p);
        if (hist.size() > DEPTH) void'(hist.pop_back());
    endtask

    task automatic step(input bit m, input int p, input bit h, input bit f, input int a,
                        input bit r);
        bit acc;
        match_signal = m;
        trade_price  = p[PW-1:0];
        halt_signal  = h;
        freeze       = f;
        rd_age       = a[AW-1:0];
        reset        = r;

        // Read sees the history as it stood before this edge
        if (!r && a < hist.size()) begin
            e_rdv = 1'b1;
            e_rdd = hist[a];
        end else begin
            e_rdv = 1'b0;
            e_rdd = 0;
        end

        acc = m && !h;
        if (r) begin
            hist.delete();
            m_pend_v = 0; m_pend = 0; m_dropped = 0;
            m_last = 0; m_max = 0; m_min = 0;
        end else if (f) begin
            if (acc) begin
                if (m_pend_v) m_dropped = 1;
                m_pend   = p & 8'hFF;
                m_pend_v = 1;
            end
        end else if (m_pend_v) begin
            model_write(m_pend);
            if (acc) m_pend = p & 8'hFF;
            else m_pend_v = 0;
        end else if (acc) begin
            model_write(p & 8'hFF);
        end

        @(posedge clk);
        #1;
        check_val("rd_data", 32'(rd_data), 32'(e_rdd));
        check_val("rd_valid", 32'(rd_valid), 32'(e_rdv));
        check_val("count", 32'(count), 32'(hist.size()));
        check_val("full", 32'(full), 32'(hist.size() == DEPTH));
        check_val("last_price", 32'(last_price), 32'(m_last));
        check_val("max_price", 32'(max_price), 32'(m_max));
        check_val("min_price", 32'(min_price), 32'(m_min));
        check_val("dropped", 32'(dropped), 32'(m_dropped));
    endtask

    initial begin
        bit frz;
        hist.delete();
        m_pend_v = 0; m_pend = 0; m_dropped = 0;
        m_last = 0; m_max = 0; m_min = 0;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Three trades then read ages 0..3
        step(1, 10, 0, 0, 0, 0);
        step(1, 20, 0, 0, 0, 0);
        step(1, 30, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) step(0, 0, 0, 0, a, 0);
        check_val("basic_count", 32'(count), 32'd3);
        check_val("basic_max", 32'(max_price), 32'd30);
        check_val("basic_min", 32'(min_price), 32'd10);

        // Wrap: 17 trades of 1..17
        step(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 17; i++) step(1, i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_val("wrap_newest", 32'(rd_data), 32'd17);
        step(0, 0, 0, 0, 15, 0);
        check_val("wrap_oldest", 32'(rd_data), 32'd2);
        check_val("wrap_full", 32'(full), 32'd1);

        // Halt suppresses capture
        step(1, 99, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_val("halt_last", 32'(last_price), 32'd17);

        // Freeze: 40 then 50, then release
        step(0, 0, 0, 0, 0, 1);
        step(1, 40, 0, 1, 0, 0);
        step(1, 50, 0, 1, 0, 0);
        check_val("frz_count", 32'(count), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check_val("frz_dropped", 32'(dropped), 32'd1);
        check_val("frz_last", 32'(last_price), 32'd50);
        check_val("frz_count1", 32'(count), 32'd1);

        // Freeze falls with 55 pending and 60 arriving
        step(1, 55, 0, 1, 0, 0);
        step(1, 60, 0, 0, 0, 0);
        check_val("fall_last55", 32'(last_price), 32'd55);
        step(0, 0, 0, 0, 0, 0);
        check_val("fall_last60", 32'(last_price), 32'd60);
        step(0, 0, 0, 0, 0, 0);
        check_val("fall_rd60", 32'(rd_data), 32'd60);

        // Reset mid-freeze with pending entry
        step(1, 77, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        step(1, 8, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_val("rst_count", 32'(count), 32'd1);
        check_val("rst_max", 32'(max_price), 32'd8);
        check_val("rst_min", 32'(min_price), 32'd8);
        check_val("rst_rd", 32'(rd_data), 32'd8);

        // Random traffic
        frz = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) frz = !frz;
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
                 $urandom_range(0, 9) == 0, frz, int'($urandom_range(0, DEPTH - 1)),
                 $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
